// File: rtl/queue.sv
// rtl/queue.sv - order-preserving fixed-capacity queue with per-slot random-access pop
module queue #(
  parameter int  Size = 4,
  parameter type T    = logic [7:0]
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  T                           i_data,
  input  logic                       i_pop  [Size-1:0],
  output logic [$clog2(Size+1)-1:0]  o_size,
  output T                           o_data [Size-1:0]
);

  localparam int SW = $clog2(Size + 1);
  typedef logic [SW-1:0] cnt_t;

  T     data_q [Size-1:0];
  T     data_d [Size-1:0];
  cnt_t size_q;
  cnt_t size_d;

  cnt_t popped;
  cnt_t dst;
  cnt_t kept;

  // Compact survivors toward slot 0 (dest = index minus pops below it), then append
  // the push after the survivors if there is room.
  always_comb begin
    for (int j = 0; j < Size; j++) begin
      data_d[j] = '0;
    end
    popped = '0;
    dst    = '0;
    for (int k = 0; k < Size; k++) begin
      if (cnt_t'(k) < size_q) begin
        if (i_pop[k]) begin
          popped = popped + cnt_t'(1);
        end else begin
          dst = cnt_t'(k) - popped;
          for (int j = 0; j < Size; j++) begin
            if (cnt_t'(j) == dst) begin
              data_d[j] = data_q[k];
            end
          end
        end
      end
    end
    kept   = size_q - popped;
    size_d = kept;
    if (i_push && (kept < cnt_t'(Size))) begin
      for (int j = 0; j < Size; j++) begin
        if (cnt_t'(j) == kept) begin
          data_d[j] = i_data;
        end
      end
      size_d = kept + cnt_t'(1);
    end
  end

  // Storage and occupancy registers; reset clears everything immediately.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      size_q <= '0;
      for (int j = 0; j < Size; j++) begin
        data_q[j] <= '0;
      end
    end else begin
      size_q <= size_d;
      for (int j = 0; j < Size; j++) begin
        data_q[j] <= data_d[j];
      end
    end
  end

  assign o_size = size_q;
  assign o_data = data_q;

endmodule

// File: tb/tb_queue.sv
// tb/tb_queue.sv - scoreboard testbench for queue
module tb_queue;

  localparam int N = 4;

  typedef struct {
    int         size;
    logic [7:0] d [N];
    string      tag;
  } snap_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       push = 1'b0;
  logic [7:0] din = '0;
  logic       pop [N-1:0];
  logic [2:0] size;
  logic [7:0] dout [N-1:0];

  logic [7:0] model [$];
  snap_t      sb [$];
  int         n_vec = 0;
  int         n_bad = 0;

  queue #(.Size(N), .T(logic [7:0])) dut (
    .i_clk (clk),
    .i_rst (rst),
    .i_push(push),
    .i_data(din),
    .i_pop (pop),
    .o_size(size),
    .o_data(dout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic snap_t model_snap(input string tag);
    snap_t s;
    s.size = model.size();
    s.tag  = tag;
    for (int k = 0; k < N; k++) s.d[k] = (k < model.size()) ? model[k] : 8'd0;
    return s;
  endfunction

  task automatic compare_dut(input snap_t s);
    check($sformatf("%s.size", s.tag), int'(size), s.size);
    for (int k = 0; k < N; k++)
      check($sformatf("%s.d%0d", s.tag, k), int'(dout[k]), int'(s.d[k]));
  endtask

  // Drive one cycle of stimulus, predict the result, and compare after the edge.
  task automatic do_op(input string tag, input logic p, input logic [7:0] d, input logic [N-1:0] m);
    logic [7:0] nxt [$];
    @(negedge clk);
    push = p;
    din  = d;
    for (int k = 0; k < N; k++) pop[k] = m[k];
    for (int k = 0; k < model.size(); k++) if (!m[k]) nxt.push_back(model[k]);
    if (p && nxt.size() < N) nxt.push_back(d);
    model = nxt;
    sb.push_back(model_snap(tag));
    @(posedge clk);
    #1;
    compare_dut(sb.pop_front());
    push = 1'b0;
    for (int k = 0; k < N; k++) pop[k] = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < N; k++) pop[k] = 1'b0;
    rst = 1'b1;
    #12;
    compare_dut(model_snap("reset"));
    @(negedge clk);
    rst = 1'b0;

    do_op("push0", 1'b1, 8'd0, 4'b0000);
    do_op("push2", 1'b1, 8'd2, 4'b0000);
    do_op("push4", 1'b1, 8'd4, 4'b0000);
    do_op("push6", 1'b1, 8'd6, 4'b0000);
    do_op("pop02", 1'b0, 8'd0, 4'b0101);
    do_op("beyond", 1'b1, 8'd5, 4'b1000);
    do_op("popall", 1'b0, 8'd0, 4'b1111);
    do_op("p0", 1'b1, 8'd0, 4'b0000);
    do_op("p2", 1'b1, 8'd2, 4'b0000);
    do_op("p4", 1'b1, 8'd4, 4'b0000);
    do_op("p6", 1'b1, 8'd6, 4'b0000);
    do_op("fulldrop", 1'b1, 8'd9, 4'b0000);
    do_op("fullpoppush", 1'b1, 8'd9, 4'b0010);
    do_op("fullclear", 1'b0, 8'd0, 4'b1111);
    do_op("emptymask", 1'b1, 8'd3, 4'b1111);

    for (int i = 0; i < 40; i++)
      do_op($sformatf("rnd%0d", i), 1'($urandom_range(0, 3) != 0),
            8'($urandom_range(1, 255)), 4'($urandom_range(0, 15) & $urandom_range(0, 15)));

    // Asynchronous reset between clock edges with a non-empty queue.
    do_op("prefill", 1'b1, 8'd11, 4'b0000);
    @(negedge clk);
    #2;
    rst = 1'b1;
    model.delete();
    #1;
    compare_dut(model_snap("async_rst"));
    @(negedge clk);
    rst = 1'b0;
    do_op("push7", 1'b1, 8'd7, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/queue.md
Name: queue

Overview:
- Synchronous, order-preserving, fixed-capacity queue with random-access removal.
- Entries are appended at the tail and are always visible in parallel on an output array, with the oldest entry at index 0.
- Any subset of entries can be removed in one cycle through a per-slot pop mask. Survivors compact toward index 0 and keep their relative order.
- Serves as a small scheduling/issue buffer where consumers retire entries out of order.

Parameters:
- Size, 4, capacity in entries; must be >= 1.
- T, logic [7:0], entry data type (type parameter); any packed type.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_push  input  1  append i_data at the tail this cycle.
- i_data  input  T  entry to append.
- i_pop  input  1 x [Size] (unpacked array, index Size-1..0)  i_pop[k]=1 removes entry k this cycle.
- o_size  output  $clog2(Size+1)  number of valid entries, 0..Size.
- o_data  output  T x [Size] (unpacked array)  registered storage; o_data[0] is the oldest entry.

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset: immediately and while asserted, o_size=0 and every o_data[k]=0. Reset asserted mid-operation discards all contents.
- All outputs are registered. An operation sampled at edge N is visible after edge N, so latency is 1 cycle. There are no combinational paths from inputs to outputs.
- Valid entries occupy o_data[0..o_size-1]. Slots at index >= o_size read 0.
- Pop:
  - Mask bits i_pop[k] with k >= o_size are ignored.
  - Let R = number of valid k with i_pop[k]=1.
  - Non-popped valid entries move to indices 0..o_size-R-1 in their original relative order.
  - Vacated slots are cleared to 0.
- Push:
  - Accepted when (o_size - R) < Size.
  - The accepted entry is written to index (o_size - R), i.e. after compaction.
  - A push is silently dropped when the queue is full and no valid entry is popped in the same cycle. Size and contents are then unchanged.
- Simultaneous push and pop: pops apply first, then the push. A full queue with at least one valid pop accepts the push.
- Next size = o_size - R + (push accepted). This value never exceeds Size and never underflows.
- Push with an empty queue and a pop mask set is legal: the mask is ignored and the entry lands at index 0.
- All-ones pop on a full queue with no push: queue becomes empty, o_size=0, all o_data=0.
- No state machine. State is the storage array plus the size counter.
- Compaction is combinational within one cycle. Destination index of each survivor = its index minus the number of popped valid entries below it. No iterative shifting across cycles.

Test Plan:
- Reset, then push 0, then push 2 (one per cycle) -> o_size=2, o_data[0]=0, o_data[1]=2, o_data[2]=o_data[3]=0.
- Continue pushing 4, then 6 -> o_size=4, o_data = 0,2,4,6 (index 0..3).
- From {0,2,4,6}, pop mask i_pop[0]=1, i_pop[2]=1, others 0, no push -> o_size=2, o_data[0]=2, o_data[1]=6, o_data[2]=o_data[3]=0.
- Full {0,2,4,6}, push 9 with no pop -> push dropped, o_size=4, contents unchanged. Then push 9 with i_pop[1]=1 -> o_size=4, o_data = 0,4,6,9.
- Queue of size 2 {2,6}, i_pop[3]=1 only (beyond o_size) with push 5 -> mask ignored, o_size=3, o_data = 2,6,5.
- Assert i_rst asynchronously (between clock edges) with a non-empty queue -> o_size=0 and all o_data=0 immediately. After release, a push 7 -> o_size=1, o_data[0]=7.
